xcpt_arbiter: RTL and testbench
===============================

XCPT_ARBITER -- requirements
Module: xcpt_arbiter

Interface
REQ-001 SHALL have parameter NUM_SRC, default 8: number of exception sources, range 2..32.
REQ-002 SHALL have parameter CAUSE_W, default 64: cause and trap-value width.
REQ-003 SHALL have parameter CNT_W, default 8: lost-request counter width.
REQ-004 SHALL have port clk_i, input, 1: the block's single clock.
REQ-005 SHALL have port rst_i, input, 1: asynchronous, active-high reset.
REQ-006 SHALL have port src_mask_i, input, NUM_SRC: per-source enable; 0 ignores that source.
REQ-007 SHALL have port src_req_i, input, NUM_SRC: exception request per source; bit 0 is highest priority.
REQ-008 SHALL have port src_cause_i, input, NUM_SRC*CAUSE_W: packed causes; source k occupies bits [k*CAUSE_W +: CAUSE_W].
REQ-009 SHALL have port src_tval_i, input, NUM_SRC*CAUSE_W: packed trap values, same packing as src_cause_i (XCPT_TVAL_EN only).
REQ-010 SHALL have port flush_i, input, 1: pipeline flush; discards the pending exception.
REQ-011 SHALL have port xcpt_valid_o, output, 1: a captured exception is pending.
REQ-012 SHALL have port xcpt_ready_i, input, 1: consumer (CSR unit) accepts the pending exception.
REQ-013 SHALL have port xcpt_cause_o, output, CAUSE_W: cause of the captured exception.
REQ-014 SHALL have port xcpt_src_o, output, $clog2(NUM_SRC): index of the winning source.
REQ-015 SHALL have port xcpt_tval_o, output, CAUSE_W: captured trap value (XCPT_TVAL_EN only).
REQ-016 SHALL have port lost_cnt_o, output, CNT_W: saturating count of requests not captured.

Function
REQ-017 SHALL compute eff = src_req_i & src_mask_i, and the winner SHALL be the lowest set index of eff.
REQ-018 SHALL implement a two-state FSM, IDLE and PEND.
REQ-019 SHALL, in IDLE with eff != 0 and flush_i = 0, register the winner's cause, index and tval and go to PEND; xcpt_valid_o SHALL rise the following cycle (1-cycle latency).
REQ-020 SHALL hold xcpt_cause_o, xcpt_src_o and xcpt_tval_o stable in PEND until the state is left.
REQ-021 SHALL, in PEND with xcpt_ready_i = 1, go to IDLE; a new capture SHALL NOT occur in that same cycle (minimum 1 bubble).
REQ-022 SHALL give flush_i priority over ready and capture: in any state it forces IDLE, with no capture that cycle.
REQ-023 SHALL drive xcpt_valid_o = 1 exactly when the state is PEND, as a registered output.
REQ-024 SHALL increment lost_cnt_o by 1 in each cycle where eff != 0 and no capture occurs (PEND, or flush_i = 1).
REQ-025 SHALL increment lost_cnt_o by 1 in each capture cycle where eff has more than one bit set.
REQ-026 SHALL saturate lost_cnt_o at 2^CNT_W-1, and neither flush_i nor ready SHALL clear it.
REQ-027 SHALL treat xcpt_ready_i as don't-care in IDLE.

Reset
REQ-028 SHALL, on asserting rst_i, immediately drive state = IDLE, xcpt_valid_o = 0, xcpt_cause_o = 0, xcpt_src_o = 0, xcpt_tval_o = 0 and lost_cnt_o = 0.
REQ-029 SHALL, when rst_i asserts mid-PEND, drop the pending exception without handshake.
REQ-030 SHALL ignore requests present on the first edge after rst_i deasserts only when rst_i is still high at that edge.

Configuration
REQ-031 SHALL, with macro XCPT_TVAL_EN defined, provide src_tval_i and xcpt_tval_o and their capture registers.
REQ-032 SHALL, without XCPT_TVAL_EN, remove both ports and the tval registers; all other behaviour is identical.

Structure
REQ-033 SHALL take the default CAUSE_W (64), the FSM state enum and the RISC-V cause code constants from shared package xcpt_pkg.
REQ-034 SHALL place the combinational winner selection in sub-module xcpt_prio_enc (inputs: eff and packed causes; outputs: any, index, cause).

Verification
REQ-035 SHALL verify: eff = 8'b0010_0100, cause2 = 64'h5 -> next cycle valid = 1, cause = 64'h5, src = 2, and lost_cnt_o +1 (multi-hit).
REQ-036 SHALL verify: PEND held with ready = 0 for 5 cycles and src7 requesting each cycle -> outputs stable, lost_cnt_o +5.
REQ-037 SHALL verify: ready = 1 with src1 requesting in the same cycle -> IDLE, src1 captured the following cycle, valid = 1 one cycle after that.
REQ-038 SHALL verify: flush_i = 1 and ready = 1 together in PEND -> IDLE, no capture, valid = 0 next cycle.
REQ-039 SHALL verify: src_mask_i = 8'hFE, src_req_i = 8'h03 -> src = 1 captured.
REQ-040 SHALL verify: CNT_W = 2 with 6 lost requests -> lost_cnt_o = 3; rst_i pulsed mid-PEND -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/xcpt_pkg.sv
// Shared types and constants for the exception arbiter: default cause width,
// FSM state encoding, RISC-V cause codes and a small multi-hot helper.
package xcpt_pkg;

  localparam int CAUSE_W_DEF = 64;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_PEND = 1'b1
  } state_t;

  localparam logic [63:0] CAUSE_INSN_MISALIGNED  = 64'd0;
  localparam logic [63:0] CAUSE_INSN_ACCESS      = 64'd1;
  localparam logic [63:0] CAUSE_ILLEGAL_INSN     = 64'd2;
  localparam logic [63:0] CAUSE_BREAKPOINT       = 64'd3;
  localparam logic [63:0] CAUSE_LOAD_MISALIGNED  = 64'd4;
  localparam logic [63:0] CAUSE_LOAD_ACCESS      = 64'd5;
  localparam logic [63:0] CAUSE_STORE_MISALIGNED = 64'd6;
  localparam logic [63:0] CAUSE_STORE_ACCESS     = 64'd7;
  localparam logic [63:0] CAUSE_ECALL_U          = 64'd8;
  localparam logic [63:0] CAUSE_ECALL_S          = 64'd9;
  localparam logic [63:0] CAUSE_ECALL_M          = 64'd11;
  localparam logic [63:0] CAUSE_INSN_PAGE_FAULT  = 64'd12;
  localparam logic [63:0] CAUSE_LOAD_PAGE_FAULT  = 64'd13;
  localparam logic [63:0] CAUSE_STORE_PAGE_FAULT = 64'd15;

  // True when more than one bit of v is set.
  function automatic logic multi_hot(input logic [31:0] v);
    return (v & (v - 32'd1)) != 32'd0;
  endfunction

endpackage

// File: rtl/xcpt_prio_enc.sv
// Fixed-priority encoder: picks the lowest set index of eff and muxes out its cause.
module xcpt_prio_enc #(
  parameter int NUM_SRC = 8,
  parameter int CAUSE_W = 64,
  parameter int IDX_W   = $clog2(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0]         eff,
  input  logic [NUM_SRC*CAUSE_W-1:0] causes,
  output logic                       any,
  output logic [IDX_W-1:0]           index,
  output logic [CAUSE_W-1:0]         cause
);

  // Scan high to low so the lowest requesting index is written last and wins.
  always_comb begin
    any   = 1'b0;
    index = '0;
    cause = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (eff[i]) begin
        any   = 1'b1;
        index = IDX_W'(i);
        cause = causes[i*CAUSE_W +: CAUSE_W];
      end
    end
  end

endmodule

// File: rtl/xcpt_arbiter.sv
// Exception arbiter: captures the highest-priority enabled request and holds it
// until consumed or flushed. Trap-value path is present only with XCPT_TVAL_EN.
module xcpt_arbiter
  import xcpt_pkg::*;
#(
  parameter int NUM_SRC = 8,
  parameter int CAUSE_W = CAUSE_W_DEF,
  parameter int CNT_W   = 8
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [NUM_SRC-1:0]           src_mask_i,
  input  logic [NUM_SRC-1:0]           src_req_i,
  input  logic [NUM_SRC*CAUSE_W-1:0]   src_cause_i,
`ifdef XCPT_TVAL_EN
  input  logic [NUM_SRC*CAUSE_W-1:0]   src_tval_i,
  output logic [CAUSE_W-1:0]           xcpt_tval_o,
`endif
  input  logic                         flush_i,
  output logic                         xcpt_valid_o,
  input  logic                         xcpt_ready_i,
  output logic [CAUSE_W-1:0]           xcpt_cause_o,
  output logic [$clog2(NUM_SRC)-1:0]   xcpt_src_o,
  output logic [CNT_W-1:0]             lost_cnt_o
);

  localparam int IDX_W = $clog2(NUM_SRC);

  state_t             state_reg;
  logic               valid_reg;
  logic [CAUSE_W-1:0] cause_reg;
  logic [IDX_W-1:0]   src_reg;
  logic [CNT_W-1:0]   lost_reg;

  logic [NUM_SRC-1:0] eff;
  logic               any;
  logic [IDX_W-1:0]   win_index;
  logic [CAUSE_W-1:0] win_cause;
  logic               capture;
  logic               lost_inc;

  assign eff = src_req_i & src_mask_i;

  xcpt_prio_enc #(
    .NUM_SRC (NUM_SRC),
    .CAUSE_W (CAUSE_W),
    .IDX_W   (IDX_W)
  ) u_prio_enc (
    .eff    (eff),
    .causes (src_cause_i),
    .any    (any),
    .index  (win_index),
    .cause  (win_cause)
  );

  assign capture  = (state_reg == ST_IDLE) && any && !flush_i;
  // Requests that arrive while busy or flushed are lost, as are the losers of a multi-hit capture.
  assign lost_inc = (any && !capture) || (capture && multi_hot(32'(eff)));

`ifdef XCPT_TVAL_EN
  logic [CAUSE_W-1:0] tval_reg;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      tval_reg <= '0;
    end else if (capture) begin
      tval_reg <= src_tval_i[win_index*CAUSE_W +: CAUSE_W];
    end
  end

  assign xcpt_tval_o = tval_reg;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg <= ST_IDLE;
      valid_reg <= 1'b0;
      cause_reg <= '0;
      src_reg   <= '0;
      lost_reg  <= '0;
    end else begin
      if (lost_inc && (lost_reg != {CNT_W{1'b1}})) begin
        lost_reg <= lost_reg + CNT_W'(1);
      end
      if (flush_i) begin
        state_reg <= ST_IDLE;
        valid_reg <= 1'b0;
      end else begin
        case (state_reg)
          ST_IDLE: begin
            if (any) begin
              state_reg <= ST_PEND;
              valid_reg <= 1'b1;
              cause_reg <= win_cause;
              src_reg   <= win_index;
            end
          end
          ST_PEND: begin
            if (xcpt_ready_i) begin
              state_reg <= ST_IDLE;
              valid_reg <= 1'b0;
            end
          end
          default: begin
            state_reg <= ST_IDLE;
            valid_reg <= 1'b0;
          end
        endcase
      end
    end
  end

  assign xcpt_valid_o = valid_reg;
  assign xcpt_cause_o = cause_reg;
  assign xcpt_src_o   = src_reg;
  assign lost_cnt_o   = lost_reg;

endmodule

// File: tb/tb_xcpt_arbiter.sv
// Table-driven bench for xcpt_arbiter with a scoreboard queue; a second instance
// with a 2-bit lost counter checks saturation. Checks tval when XCPT_TVAL_EN is set.
module tb_xcpt_arbiter;

  localparam int NUM_SRC = 8;
  localparam int CAUSE_W = 64;

  logic                       clk_i = 1'b0;
  logic                       rst_i;
  logic [NUM_SRC-1:0]         src_mask_i;
  logic [NUM_SRC-1:0]         src_req_i;
  logic [NUM_SRC*CAUSE_W-1:0] src_cause_i;
  logic                       flush_i;
  logic                       xcpt_ready_i;

  logic                       valid_a, valid_b;
  logic [CAUSE_W-1:0]         cause_a, cause_b;
  logic [2:0]                 src_a, src_b;
  logic [7:0]                 lost_a;
  logic [1:0]                 lost_b;

`ifdef XCPT_TVAL_EN
  logic [NUM_SRC*CAUSE_W-1:0] src_tval_i;
  logic [CAUSE_W-1:0]         tval_a, tval_b;
`endif

  always #5 clk_i = ~clk_i;

  xcpt_arbiter #(.NUM_SRC(NUM_SRC), .CAUSE_W(CAUSE_W), .CNT_W(8)) dut_a (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .src_mask_i   (src_mask_i),
    .src_req_i    (src_req_i),
    .src_cause_i  (src_cause_i),
`ifdef XCPT_TVAL_EN
    .src_tval_i   (src_tval_i),
    .xcpt_tval_o  (tval_a),
`endif
    .flush_i      (flush_i),
    .xcpt_valid_o (valid_a),
    .xcpt_ready_i (xcpt_ready_i),
    .xcpt_cause_o (cause_a),
    .xcpt_src_o   (src_a),
    .lost_cnt_o   (lost_a)
  );

  xcpt_arbiter #(.NUM_SRC(NUM_SRC), .CAUSE_W(CAUSE_W), .CNT_W(2)) dut_b (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .src_mask_i   (src_mask_i),
    .src_req_i    (src_req_i),
    .src_cause_i  (src_cause_i),
`ifdef XCPT_TVAL_EN
    .src_tval_i   (src_tval_i),
    .xcpt_tval_o  (tval_b),
`endif
    .flush_i      (flush_i),
    .xcpt_valid_o (valid_b),
    .xcpt_ready_i (xcpt_ready_i),
    .xcpt_cause_o (cause_b),
    .xcpt_src_o   (src_b),
    .lost_cnt_o   (lost_b)
  );

  typedef struct {
    logic [7:0]  mask;
    logic [7:0]  req;
    logic        flush;
    logic        ready;
    logic        exp_valid;
    logic [2:0]  exp_src;
    logic [63:0] exp_cause;
    logic [7:0]  exp_lost;
  } vec_t;

  typedef struct {
    int          idx;
    logic        valid;
    logic [2:0]  src;
    logic [63:0] cause;
    logic [7:0]  lost;
  } exp_t;

  localparam int NVEC = 17;
  vec_t vecs [NVEC];
  exp_t sb [$];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // Compare both instances against one expected record; lost_b is the 2-bit saturated view.
  task automatic compare(input exp_t e);
    logic [7:0] lost_sat;
    lost_sat = (e.lost > 8'd3) ? 8'd3 : e.lost;
    $display("txn %0d: valid=%0b src=%0d cause=%0h lost=%0d lost2=%0d",
             e.idx, valid_a, src_a, cause_a, lost_a, lost_b);
    chk($sformatf("valid_a[%0d]", e.idx), 64'(valid_a), 64'(e.valid));
    chk($sformatf("valid_b[%0d]", e.idx), 64'(valid_b), 64'(e.valid));
    chk($sformatf("lost_a[%0d]", e.idx), 64'(lost_a), 64'(e.lost));
    chk($sformatf("lost_b[%0d]", e.idx), 64'(lost_b), 64'(lost_sat));
    if (e.valid) begin
      chk($sformatf("src_a[%0d]", e.idx), 64'(src_a), 64'(e.src));
      chk($sformatf("cause_a[%0d]", e.idx), cause_a, e.cause);
      chk($sformatf("src_b[%0d]", e.idx), 64'(src_b), 64'(e.src));
      chk($sformatf("cause_b[%0d]", e.idx), cause_b, e.cause);
`ifdef XCPT_TVAL_EN
      chk($sformatf("tval_a[%0d]", e.idx), tval_a, 64'hA000 + 64'(e.src));
      chk($sformatf("tval_b[%0d]", e.idx), tval_b, 64'hA000 + 64'(e.src));
`endif
    end
  endtask

  task automatic drive_push(input int idx, input vec_t v);
    exp_t e;
    @(negedge clk_i);
    src_mask_i   = v.mask;
    src_req_i    = v.req;
    flush_i      = v.flush;
    xcpt_ready_i = v.ready;
    e.idx   = idx;
    e.valid = v.exp_valid;
    e.src   = v.exp_src;
    e.cause = v.exp_cause;
    e.lost  = v.exp_lost;
    sb.push_back(e);
  endtask

  task automatic edge_pop();
    exp_t e;
    @(posedge clk_i);
    #1;
    if (sb.size() == 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL scoreboard: got empty queue, required one entry");
    end else begin
      e = sb.pop_front();
      compare(e);
    end
  endtask

  initial begin
    // Source k reports cause k+3 (so source 2 -> 5) and trap value 0xA000+k.
    for (int k = 0; k < NUM_SRC; k++) begin
      src_cause_i[k*CAUSE_W +: CAUSE_W] = 64'(k + 3);
`ifdef XCPT_TVAL_EN
      src_tval_i[k*CAUSE_W +: CAUSE_W] = 64'hA000 + 64'(k);
`endif
    end

    //         mask   req    fl    rdy   valid src   cause   lost
    vecs[0]  = '{8'hFF, 8'h00, 1'b0, 1'b0, 1'b0, 3'd0, 64'd0,  8'd0};
    vecs[1]  = '{8'hFF, 8'h24, 1'b0, 1'b0, 1'b1, 3'd2, 64'd5,  8'd1};
    vecs[2]  = '{8'hFF, 8'h80, 1'b0, 1'b0, 1'b1, 3'd2, 64'd5,  8'd2};
    vecs[3]  = '{8'hFF, 8'h80, 1'b0, 1'b0, 1'b1, 3'd2, 64'd5,  8'd3};
    vecs[4]  = '{8'hFF, 8'h80, 1'b0, 1'b0, 1'b1, 3'd2, 64'd5,  8'd4};
    vecs[5]  = '{8'hFF, 8'h80, 1'b0, 1'b0, 1'b1, 3'd2, 64'd5,  8'd5};
    vecs[6]  = '{8'hFF, 8'h80, 1'b0, 1'b0, 1'b1, 3'd2, 64'd5,  8'd6};
    vecs[7]  = '{8'hFF, 8'h02, 1'b0, 1'b1, 1'b0, 3'd0, 64'd0,  8'd7};
    vecs[8]  = '{8'hFF, 8'h02, 1'b0, 1'b0, 1'b1, 3'd1, 64'd4,  8'd7};
    vecs[9]  = '{8'hFF, 8'h00, 1'b1, 1'b1, 1'b0, 3'd0, 64'd0,  8'd7};
    vecs[10] = '{8'hFF, 8'h00, 1'b0, 1'b0, 1'b0, 3'd0, 64'd0,  8'd7};
    vecs[11] = '{8'hFE, 8'h03, 1'b0, 1'b0, 1'b1, 3'd1, 64'd4,  8'd7};
    vecs[12] = '{8'hFF, 8'h00, 1'b0, 1'b1, 1'b0, 3'd0, 64'd0,  8'd7};
    vecs[13] = '{8'hFF, 8'h01, 1'b1, 1'b0, 1'b0, 3'd0, 64'd0,  8'd8};
    vecs[14] = '{8'h7F, 8'h80, 1'b0, 1'b0, 1'b0, 3'd0, 64'd0,  8'd8};
    vecs[15] = '{8'hFF, 8'h80, 1'b0, 1'b0, 1'b1, 3'd7, 64'd10, 8'd8};
    vecs[16] = '{8'hFF, 8'h00, 1'b0, 1'b0, 1'b1, 3'd7, 64'd10, 8'd8};

    rst_i        = 1'b1;
    src_mask_i   = 8'hFF;
    src_req_i    = 8'h00;
    flush_i      = 1'b0;
    xcpt_ready_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    chk("rst_valid", 64'(valid_a), 64'd0);
    chk("rst_cause", cause_a, 64'd0);
    chk("rst_src",   64'(src_a), 64'd0);
    chk("rst_lost",  64'(lost_a), 64'd0);
    @(negedge clk_i);
    rst_i = 1'b0;

    for (int i = 0; i < NVEC; i++) begin
      drive_push(i, vecs[i]);
      edge_pop();
    end

    // Reset mid-PEND, between clock edges: outputs must clear without waiting for an edge.
    #3;
    rst_i = 1'b1;
    #1;
    $display("txn async_rst: valid=%0b src=%0d cause=%0h lost=%0d", valid_a, src_a, cause_a, lost_a);
    chk("arst_valid_a", 64'(valid_a), 64'd0);
    chk("arst_cause_a", cause_a, 64'd0);
    chk("arst_src_a",   64'(src_a), 64'd0);
    chk("arst_lost_a",  64'(lost_a), 64'd0);
    chk("arst_valid_b", 64'(valid_b), 64'd0);
    chk("arst_lost_b",  64'(lost_b), 64'd0);

    // Requests at an edge while reset is still high are ignored.
    @(negedge clk_i);
    src_req_i = 8'hFF;
    @(posedge clk_i);
    #1;
    $display("txn rst_held: valid=%0b lost=%0d", valid_a, lost_a);
    chk("rst_held_valid", 64'(valid_a), 64'd0);
    chk("rst_held_lost",  64'(lost_a), 64'd0);
    @(negedge clk_i);
    rst_i     = 1'b0;
    src_req_i = 8'h00;

    drive_push(100, '{8'hFF, 8'h01, 1'b0, 1'b0, 1'b1, 3'd0, 64'd3, 8'd0});
    edge_pop();

    if (sb.size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d entries, required 0", sb.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
